move_objects: RTL and testbench

Time-multiplexed motion integrator for up to N_OBJ sprites (ship, asteroids, shots). It is the multi-object successor to the single-ship mover. A single update engine walks all objects once per position tick. For each object it fetches heading sin/cos through an index/lookup handshake, applies thrust, collision stop and optional drag, integrates subpixel position, and either wraps or bounces at screen edges. A load port lets game logic spawn or teleport any object.

---
 rtl/move_objects.sv | 212 +++++++++++++++++++++
 tb/tb_move_objects.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/move_objects.sv
// rtl/move_objects.sv - time-multiplexed motion integrator for N_OBJ sprites
// Define MOVE_OBJECTS_DRAG_EN to decay speed on button ticks without thrust.
module move_objects #(
  parameter int          WIDTH       = 640,
  parameter int          HEIGHT      = 480,
  parameter int          N_OBJ       = 4,
  parameter int          XY_FRACTION = 16,
  parameter int          SPEED_W     = 30,
  parameter logic [17:0] THRUST      = 18'd25,
  parameter int          DIVIDER     = 125_000,
  parameter int          BTN_DIVIDER = 20,
  parameter int          BOUNCE      = 0,
  parameter int          DRAG_SHIFT  = 4,
  localparam int         IDX_W       = (N_OBJ > 1) ? $clog2(N_OBJ) : 1,
  localparam int         X_W         = $clog2(WIDTH),
  localparam int         Y_W         = $clog2(HEIGHT)
) (
  input  logic                      clk,
  input  logic                      resetN,
  input  logic [N_OBJ-1:0]          thrust,
  input  logic [N_OBJ-1:0]          collision,
  output logic [IDX_W-1:0]          obj_idx,
  input  logic signed [17:0]        sin_val,
  input  logic signed [17:0]        cos_val,
  input  logic                      load_valid,
  input  logic [IDX_W-1:0]          load_idx,
  input  logic [X_W-1:0]            load_x,
  input  logic [Y_W-1:0]            load_y,
  input  logic signed [SPEED_W-1:0] load_vx,
  input  logic signed [SPEED_W-1:0] load_vy,
  output logic [N_OBJ*X_W-1:0]      pos_x,
  output logic [N_OBJ*Y_W-1:0]      pos_y,
  output logic                      busy,
  output logic                      frame_done
);
  localparam int XF_W   = X_W + XY_FRACTION;
  localparam int YF_W   = Y_W + XY_FRACTION;
  localparam int PX_W   = XF_W + 2;
  localparam int PY_W   = YF_W + 2;
  localparam int SHIFT  = 27 - XY_FRACTION;
  localparam int TICK_W = $clog2(DIVIDER);
  localparam int BTN_W  = $clog2(BTN_DIVIDER + 1);
  localparam logic signed [PX_W-1:0] X_LIM = PX_W'(WIDTH) <<< XY_FRACTION;
  localparam logic signed [PY_W-1:0] Y_LIM = PY_W'(HEIGHT) <<< XY_FRACTION;
  localparam logic [XF_W-1:0] X_RST = XF_W'(WIDTH / 2) << XY_FRACTION;
  localparam logic [YF_W-1:0] Y_RST = YF_W'(HEIGHT / 2) << XY_FRACTION;

  if (DIVIDER < 2 * N_OBJ + 2) begin : g_bad_divider
    $error("move_objects: DIVIDER must be at least 2*N_OBJ+2");
  end
  if (DRAG_SHIFT < 0) begin : g_bad_drag
    $error("move_objects: DRAG_SHIFT must be non-negative");
  end

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

  state_t                    r_state, w_next_state;
  logic [IDX_W-1:0]          r_idx, w_next_idx;
  logic [TICK_W-1:0]         r_tick_cnt;
  logic [BTN_W-1:0]          r_btn_cnt;
  logic                      r_btn_tick;
  logic                      w_tick;
  logic signed [SPEED_W-1:0] r_inc_x, r_inc_y;
  logic signed [36:0]        w_prod_x, w_prod_y;

  logic [XF_W-1:0]           r_x  [N_OBJ];
  logic [YF_W-1:0]           r_y  [N_OBJ];
  logic signed [SPEED_W-1:0] r_vx [N_OBJ];
  logic signed [SPEED_W-1:0] r_vy [N_OBJ];
  logic [N_OBJ-1:0]          r_col;

  logic signed [SPEED_W-1:0] w_vx, w_vy, w_cx, w_cy, w_nvx, w_nvy;
  logic signed [PX_W-1:0]    w_dx, w_sx;
  logic signed [PY_W-1:0]    w_dy, w_sy;
  logic [XF_W-1:0]           w_nx;
  logic [YF_W-1:0]           w_ny;

  function automatic logic below_one_px(input logic signed [SPEED_W-1:0] v);
    return (v[SPEED_W-1 -: 3] == 3'b000) || (v[SPEED_W-1 -: 3] == 3'b111);
  endfunction

  assign w_tick     = (r_tick_cnt == TICK_W'(DIVIDER - 1));
  assign obj_idx    = r_idx;
  assign busy       = (r_state == S_READ) || (r_state == S_WRITE);
  assign frame_done = (r_state == S_DONE);
  assign w_prod_x   = $signed({1'b0, THRUST}) * cos_val;
  assign w_prod_y   = $signed({1'b0, THRUST}) * sin_val;

  for (genvar g = 0; g < N_OBJ; g++) begin : g_pos
    assign pos_x[g*X_W +: X_W] = r_x[g][XF_W-1:XY_FRACTION];
    assign pos_y[g*Y_W +: Y_W] = r_y[g][YF_W-1:XY_FRACTION];
  end

  always_comb begin
    w_next_state = r_state;
    w_next_idx   = r_idx;
    case (r_state)
      S_IDLE:  if (w_tick) begin
                 w_next_state = S_READ;
                 w_next_idx   = '0;
               end
      S_READ:  w_next_state = S_WRITE;
      S_WRITE: if (r_idx == IDX_W'(N_OBJ - 1)) begin
                 w_next_state = S_DONE;
                 w_next_idx   = '0;
               end else begin
                 w_next_state = S_READ;
                 w_next_idx   = r_idx + 1'b1;
               end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Engine result for object r_idx; only committed in S_WRITE.
  always_comb begin
    w_vx  = r_vx[r_idx];
    w_vy  = r_vy[r_idx];
    w_cx  = w_vx + r_inc_x;
    w_cy  = w_vy + r_inc_y;
    w_nvx = w_vx;
    w_nvy = w_vy;
    w_nx  = r_x[r_idx];
    w_ny  = r_y[r_idx];
    w_dx  = '0;
    w_dy  = '0;
    w_sx  = '0;
    w_sy  = '0;
    if (r_col[r_idx]) begin
      w_nvx = '0;
      w_nvy = '0;
    end else begin
      if (r_btn_tick && thrust[r_idx]) begin
        if (below_one_px(w_cx) && below_one_px(w_cy)) begin
          w_nvx = w_cx;
          w_nvy = w_cy;
        end
      end
`ifdef MOVE_OBJECTS_DRAG_EN
      else if (r_btn_tick) begin
        w_nvx = w_vx - (w_vx >>> DRAG_SHIFT);
        w_nvy = w_vy - (w_vy >>> DRAG_SHIFT);
      end
`endif
      w_dx = PX_W'(w_nvx >>> SHIFT);
      w_dy = PY_W'(w_nvy >>> SHIFT);
      w_sx = $signed({2'b00, r_x[r_idx]}) + w_dx;
      // Screen y grows downward while speed is math-up.
      w_sy = $signed({2'b00, r_y[r_idx]}) - w_dy;
      if (w_sx[PX_W-1] || w_sx >= X_LIM) begin
        if (BOUNCE != 0) w_nvx = -w_nvx;
        else if (w_sx[PX_W-1]) w_nx = XF_W'(w_sx + X_LIM);
        else w_nx = XF_W'(w_sx - X_LIM);
      end else begin
        w_nx = XF_W'(w_sx);
      end
      if (w_sy[PY_W-1] || w_sy >= Y_LIM) begin
        if (BOUNCE != 0) w_nvy = -w_nvy;
        else if (w_sy[PY_W-1]) w_ny = YF_W'(w_sy + Y_LIM);
        else w_ny = YF_W'(w_sy - Y_LIM);
      end else begin
        w_ny = YF_W'(w_sy);
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_tick_cnt <= '0;
      r_btn_cnt  <= '0;
      r_btn_tick <= 1'b0;
      r_inc_x    <= '0;
      r_inc_y    <= '0;
      r_col      <= '0;
      for (int j = 0; j < N_OBJ; j++) begin
        r_x[j]  <= X_RST;
        r_y[j]  <= Y_RST;
        r_vx[j] <= '0;
        r_vy[j] <= '0;
      end
    end else begin
      r_state    <= w_next_state;
      r_idx      <= w_next_idx;
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
      if (w_tick) begin
        r_btn_tick <= (r_btn_cnt == BTN_W'(BTN_DIVIDER - 1));
        r_btn_cnt  <= (r_btn_cnt == BTN_W'(BTN_DIVIDER - 1)) ? '0 : r_btn_cnt + 1'b1;
      end
      if (r_state == S_READ) begin
        r_inc_x <= SPEED_W'(w_prod_x);
        r_inc_y <= SPEED_W'(w_prod_y);
      end
      for (int j = 0; j < N_OBJ; j++) begin
        if (load_valid && load_idx == IDX_W'(j)) begin
          r_x[j]  <= {load_x, {XY_FRACTION{1'b0}}};
          r_y[j]  <= {load_y, {XY_FRACTION{1'b0}}};
          r_vx[j] <= load_vx;
          r_vy[j] <= load_vy;
        end else if (r_state == S_WRITE && r_idx == IDX_W'(j)) begin
          r_x[j]  <= w_nx;
          r_y[j]  <= w_ny;
          r_vx[j] <= w_nvx;
          r_vy[j] <= w_nvy;
        end
        if (collision[j]) r_col[j] <= 1'b1;
        else if ((load_valid && load_idx == IDX_W'(j)) ||
                 (r_state == S_WRITE && r_idx == IDX_W'(j))) r_col[j] <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_move_objects.sv
// tb/tb_move_objects.sv - randomized check of move_objects (wrap and bounce) against a frame-level model
module tb_move_objects;
  localparam int N = 4, DIV = 16, BTN = 2, XW = 10, YW = 9, THR = 25;
  localparam longint FR = 65536, WLIM = 640 * FR, HLIM = 480 * FR, VLIM = 134217728;

  logic clk = 1'b0;
  logic resetN;
  logic [N-1:0] thrust, collision;
  logic [1:0] idx_w, idx_b;
  logic signed [17:0] sin_w, cos_w, sin_b, cos_b;
  logic load_valid;
  logic [1:0] load_idx;
  logic [XW-1:0] load_x;
  logic [YW-1:0] load_y;
  logic signed [29:0] load_vx, load_vy;
  logic [N*XW-1:0] px_w, px_b;
  logic [N*YW-1:0] py_w, py_b;
  logic busy_w, busy_b, fd_w, fd_b;
  logic signed [17:0] sin_tab [N];
  logic signed [17:0] cos_tab [N];

  longint mx [2][N];
  longint my [2][N];
  longint mvx [2][N];
  longint mvy [2][N];
  bit mcol [N];
  int ktick = 0;
  int n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;
  assign sin_w = sin_tab[idx_w];
  assign cos_w = cos_tab[idx_w];
  assign sin_b = sin_tab[idx_b];
  assign cos_b = cos_tab[idx_b];

  move_objects #(.N_OBJ(N), .DIVIDER(DIV), .BTN_DIVIDER(BTN), .BOUNCE(0)) dut (
    .clk(clk), .resetN(resetN), .thrust(thrust), .collision(collision), .obj_idx(idx_w),
    .sin_val(sin_w), .cos_val(cos_w), .load_valid(load_valid), .load_idx(load_idx),
    .load_x(load_x), .load_y(load_y), .load_vx(load_vx), .load_vy(load_vy),
    .pos_x(px_w), .pos_y(py_w), .busy(busy_w), .frame_done(fd_w));

  move_objects #(.N_OBJ(N), .DIVIDER(DIV), .BTN_DIVIDER(BTN), .BOUNCE(1)) dut_b (
    .clk(clk), .resetN(resetN), .thrust(thrust), .collision(collision), .obj_idx(idx_b),
    .sin_val(sin_b), .cos_val(cos_b), .load_valid(load_valid), .load_idx(load_idx),
    .load_x(load_x), .load_y(load_y), .load_vx(load_vx), .load_vy(load_vy),
    .pos_x(px_b), .pos_y(py_b), .busy(busy_b), .frame_done(fd_b));

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint wrap30(input longint v);
    longint r;
    r = v & ((64'sd1 <<< 30) - 1);
    if (r >= (64'sd1 <<< 29)) r -= (64'sd1 <<< 30);
    return r;
  endfunction

  function automatic longint floor_div(input longint a, input longint b);
    return (a >= 0) ? a / b : -((-a + b - 1) / b);
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < N; i++) begin
        mx[m][i] = 320 * FR; my[m][i] = 240 * FR; mvx[m][i] = 0; mvy[m][i] = 0;
      end
    for (int i = 0; i < N; i++) mcol[i] = 0;
  endtask

  task automatic model_load(input int i, input int x, input int y, input longint vx, input longint vy);
    for (int m = 0; m < 2; m++) begin
      mx[m][i] = x * FR; my[m][i] = y * FR; mvx[m][i] = wrap30(vx); mvy[m][i] = wrap30(vy);
    end
    mcol[i] = 0;
  endtask

  // One sweep: every object integrated once; skip is the object whose result a load overrides.
  task automatic model_frame(input int skip);
    bit btn;
    longint cx, cy, vx, vy, nx, ny;
    btn = (ktick % BTN) == 0;
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < N; i++) begin
        if (i == skip) continue;
        if (mcol[i]) begin mvx[m][i] = 0; mvy[m][i] = 0; continue; end
        vx = mvx[m][i]; vy = mvy[m][i];
        if (btn && thrust[i]) begin
          cx = wrap30(vx + THR * longint'(cos_tab[i]));
          cy = wrap30(vy + THR * longint'(sin_tab[i]));
          if (cx >= -VLIM && cx < VLIM && cy >= -VLIM && cy < VLIM) begin vx = cx; vy = cy; end
        end
`ifdef MOVE_OBJECTS_DRAG_EN
        else if (btn) begin
          vx = vx - floor_div(vx, 16); vy = vy - floor_div(vy, 16);
        end
`endif
        nx = mx[m][i] + floor_div(vx, 2048);
        ny = my[m][i] - floor_div(vy, 2048);
        if (m == 0) begin
          if (nx < 0) nx += WLIM; else if (nx >= WLIM) nx -= WLIM;
          if (ny < 0) ny += HLIM; else if (ny >= HLIM) ny -= HLIM;
          mx[m][i] = nx; my[m][i] = ny;
        end else begin
          if (nx < 0 || nx >= WLIM) vx = wrap30(-vx); else mx[m][i] = nx;
          if (ny < 0 || ny >= HLIM) vy = wrap30(-vy); else my[m][i] = ny;
        end
        mvx[m][i] = vx; mvy[m][i] = vy;
      end
    for (int i = 0; i < N; i++) mcol[i] = 0;
  endtask

  task automatic compare_all(input string tag);
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s_wrap_x%0d", tag, i), longint'(px_w[i*XW +: XW]), mx[0][i] / FR);
      check($sformatf("%s_wrap_y%0d", tag, i), longint'(py_w[i*YW +: YW]), my[0][i] / FR);
      check($sformatf("%s_bnc_x%0d", tag, i), longint'(px_b[i*XW +: XW]), mx[1][i] / FR);
      check($sformatf("%s_bnc_y%0d", tag, i), longint'(py_b[i*YW +: YW]), my[1][i] / FR);
      check($sformatf("%s_wrap_vx%0d", tag, i), longint'(dut.r_vx[i]), mvx[0][i]);
      check($sformatf("%s_bnc_vy%0d", tag, i), longint'(dut_b.r_vy[i]), mvy[1][i]);
    end
  endtask

  // Runs until frame_done; with tgt>=0 a load of that object is driven during its WRITE cycle.
  task automatic wait_frame(input int tgt, input int lx, input int ly, input longint lvx, input longint lvy);
    int cyc, bcnt, hits;
    cyc = 0; bcnt = 0; hits = 0;
    forever begin
      @(negedge clk);
      cyc++;
      load_valid = 1'b0;
      if (busy_w) bcnt++;
      if (tgt >= 0 && busy_w && idx_w == 2'(tgt)) begin
        hits++;
        if (hits == 2) begin
          load_valid = 1'b1; load_idx = 2'(tgt); load_x = XW'(lx); load_y = YW'(ly);
          load_vx = 30'(lvx); load_vy = 30'(lvy);
        end
      end
      if (fd_w) break;
      if (cyc > 3 * DIV) begin
        check("frame_timeout", 0, 1);
        return;
      end
    end
    check("frame_done_lockstep", longint'(fd_b), 1);
    check("busy_cycles", bcnt, 2 * N);
    ktick++;
    model_frame(tgt);
    if (tgt >= 0) model_load(tgt, lx, ly, lvx, lvy);
    compare_all($sformatf("f%0d", ktick));
  endtask

  task automatic drive_idle(input int li, input int lx, input int ly, input longint lvx, input longint lvy, input int col);
    if (li >= 0) begin
      load_valid = 1'b1; load_idx = 2'(li); load_x = XW'(lx); load_y = YW'(ly);
      load_vx = 30'(lvx); load_vy = 30'(lvy);
      model_load(li, lx, ly, lvx, lvy);
    end
    if (col >= 0) begin collision[col] = 1'b1; mcol[col] = 1; end
    @(negedge clk);
    load_valid = 1'b0;
    collision = '0;
  endtask

  function automatic logic signed [17:0] rand_trig();
    return 18'(int'($urandom_range(0, 262142)) - 131071);
  endfunction

  function automatic longint rand_speed();
    return longint'($urandom_range(0, 134217727)) - 67108864;
  endfunction

  initial begin
    int li, col, cyc;
    resetN = 1'b0; thrust = '0; collision = '0; load_valid = 1'b0; load_idx = '0;
    load_x = '0; load_y = '0; load_vx = '0; load_vy = '0;
    for (int i = 0; i < N; i++) begin sin_tab[i] = '0; cos_tab[i] = '0; end
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_busy", longint'(busy_w), 0);
    check("rst_frame_done", longint'(fd_w), 0);
    check("rst_obj_idx", longint'(idx_w), 0);
    compare_all("rst");
    resetN = 1'b1;

    wait_frame(-1, 0, 0, 0, 0);
    @(negedge clk);
    check("frame_done_single_pulse", longint'(fd_w), 0);

    drive_idle(0, 639, 240, 64'h4000000, 0, -1);
    wait_frame(-1, 0, 0, 0, 0);
    check("wrap_x_first", longint'(px_w[XW-1:0]), 639);
    wait_frame(-1, 0, 0, 0, 0);
    check("wrap_x_second", longint'(px_w[XW-1:0]), 0);
    check("bounce_x_held", longint'(px_b[XW-1:0]), 639);
    check("bounce_vx_neg", longint'(dut_b.r_vx[0]), -64'sh4000000);
    wait_frame(-1, 0, 0, 0, 0);
    wait_frame(-1, 0, 0, 0, 0);
    check("bounce_x_falls", longint'(px_b[XW-1:0]), 638);

    thrust[1] = 1'b1; cos_tab[1] = 18'sh1FFFF; sin_tab[1] = '0;
    wait_frame(-1, 0, 0, 0, 0);
    wait_frame(-1, 0, 0, 0, 0);
    check("thrust_first_step", longint'(dut.r_vx[1]), 25 * 131071);
    for (int f = 0; f < 98; f++) wait_frame(-1, 0, 0, 0, 0);
    check("thrust_clamped", longint'(dut.r_vx[1]), 131071000);
    thrust = '0;

    drive_idle(2, 100, 100, 64'h1000000, -64'sh800000, -1);
    wait_frame(-1, 0, 0, 0, 0);
    drive_idle(-1, 0, 0, 0, 0, 2);
    check("col_latched", longint'(dut.r_col[2]), 1);
    wait_frame(-1, 0, 0, 0, 0);
    check("col_speed_zero", longint'(dut.r_vx[2]), 0);
    check("col_latch_cleared", longint'(dut.r_col[2]), 0);

    wait_frame(3, 10, 20, 64'h123456, -64'sh54321);
    check("load_in_write_x", longint'(px_w[3*XW +: XW]), 10);
    check("load_in_write_y", longint'(py_w[3*YW +: YW]), 20);
    check("load_in_write_vx", longint'(dut.r_vx[3]), 64'h123456);

    for (int f = 0; f < 60; f++) begin
      thrust = 4'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) begin sin_tab[i] = rand_trig(); cos_tab[i] = rand_trig(); end
      li = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, N - 1)) : -1;
      col = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N - 1)) : -1;
      if (col == li) col = -1;
      drive_idle(li, int'($urandom_range(0, 639)), int'($urandom_range(0, 479)), rand_speed(), rand_speed(), col);
      if ($urandom_range(0, 4) == 0)
        wait_frame(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 639)),
                   int'($urandom_range(0, 479)), rand_speed(), rand_speed());
      else
        wait_frame(-1, 0, 0, 0, 0);
    end

    cyc = 0;
    while (!busy_w && cyc < 3 * DIV) begin @(negedge clk); cyc++; end
    check("busy_before_reset", longint'(busy_w), 1);
    resetN = 1'b0;
    #1;
    model_reset();
    check("midreset_busy", longint'(busy_w), 0);
    compare_all("midrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
